// File: rtl/conv_pkg.sv
// Shared conv/deconv package: FSM encodings, dimension and flat-index helpers.
// Used by conv_transpose2d and convt_tap_gen.
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INIT_OUT = 3'd1,
      SCAN_TAP = 3'd2,
      MAC      = 3'd3,
      STORE    = 3'd4,
      DONE     = 3'd5
   } state_e;

   typedef logic [31:0] idx_t;

   function automatic int out_dim_conv(int i, int k, int s, int p);
      return (i + 2*p - k) / s + 1;
   endfunction

   function automatic int out_dim_convt(int i, int k, int s, int p);
      return (i - 1)*s - 2*p + k;
   endfunction

   function automatic idx_t idx4(idx_t b, idx_t c, idx_t y, idx_t x,
                                 int cn, int hn, int wn);
      return idx_t'(((b*cn + c)*hn + y)*wn + x);
   endfunction

   function automatic int cw(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/convt_tap_gen.sv
// Gather-form tap generator: maps an output pixel and kernel tap to the
// contributing input pixel, its validity and flat operand offsets.
module convt_tap_gen
   import conv_pkg::*;
#(
   parameter int IN_CHANNELS  = 1,
   parameter int OUT_CHANNELS = 2,
   parameter int IN_HEIGHT    = 2,
   parameter int IN_WIDTH     = 2,
   parameter int KERNEL_SIZE  = 2,
   parameter int STRIDE       = 2,
   parameter int PADDING      = 0
) (
   input  idx_t b_i,
   input  idx_t ic_i,
   input  idx_t oc_i,
   input  idx_t oy_i,
   input  idx_t ox_i,
   input  idx_t ky_i,
   input  idx_t kx_i,
   output logic tap_ok_o,
   output idx_t in_off_o,
   output idx_t w_off_o
);

   logic signed [31:0] ny, nx;
   idx_t iy, ix;
   logic y_ok, x_ok;

   assign ny = signed'(oy_i) + PADDING - signed'(ky_i);
   assign nx = signed'(ox_i) + PADDING - signed'(kx_i);
   assign iy = idx_t'(ny / STRIDE);
   assign ix = idx_t'(nx / STRIDE);

   // Negative ny/nx make iy/ix meaningless; the sign test masks them.
   assign y_ok = (ny >= 0) && (ny % STRIDE == 0) && (iy < idx_t'(IN_HEIGHT));
   assign x_ok = (nx >= 0) && (nx % STRIDE == 0) && (ix < idx_t'(IN_WIDTH));
   assign tap_ok_o = y_ok && x_ok;

   assign in_off_o = tap_ok_o ?
      idx4(b_i, ic_i, iy, ix, IN_CHANNELS, IN_HEIGHT, IN_WIDTH) : '0;
   assign w_off_o = idx4(ic_i, oc_i, ky_i, kx_i,
                         OUT_CHANNELS, KERNEL_SIZE, KERNEL_SIZE);

endmodule

// File: rtl/conv_transpose2d.sv
// Output-stationary transposed 2-D convolution, one tap per two cycles.
// Define CONVT_RELU_EN to clamp negative results to zero on store.
module conv_transpose2d
   import conv_pkg::*;
#(
   parameter int BATCH_SIZE   = 1,
   parameter int IN_CHANNELS  = 1,
   parameter int OUT_CHANNELS = 2,
   parameter int IN_HEIGHT    = 2,
   parameter int IN_WIDTH     = 2,
   parameter int KERNEL_SIZE  = 2,
   parameter int STRIDE       = 2,
   parameter int PADDING      = 0,
   parameter int DATA_WIDTH   = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]
                input_tensor_flat,
   input  logic [IN_CHANNELS*OUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]
                weights_flat,
   input  logic [OUT_CHANNELS*DATA_WIDTH-1:0] bias_flat,
   output logic [BATCH_SIZE*OUT_CHANNELS
                 *out_dim_convt(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING)
                 *out_dim_convt(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING)
                 *DATA_WIDTH-1:0] output_tensor_flat,
   output logic done,
   output logic valid
);

   localparam int OUT_HEIGHT =
      out_dim_convt(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING);
   localparam int OUT_WIDTH =
      out_dim_convt(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING);
   localparam int OUT_SIZE = BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH;
   localparam int IN_SIZE  = BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH;
   localparam int W_SIZE   = IN_CHANNELS*OUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE;
   localparam int IA = cw(IN_SIZE);
   localparam int WA = cw(W_SIZE);
   localparam int BA = cw(OUT_CHANNELS);
   localparam int OA = cw(OUT_SIZE);

   typedef logic [DATA_WIDTH-1:0] data_t;

   data_t in_arr [IN_SIZE];
   data_t w_arr  [W_SIZE];
   data_t b_arr  [OUT_CHANNELS];
   data_t out_q  [OUT_SIZE];
   data_t out_d  [OUT_SIZE];

   for (genvar g = 0; g < IN_SIZE; g++) begin : g_in
      assign in_arr[g] = input_tensor_flat[g*DATA_WIDTH +: DATA_WIDTH];
   end
   for (genvar g = 0; g < W_SIZE; g++) begin : g_w
      assign w_arr[g] = weights_flat[g*DATA_WIDTH +: DATA_WIDTH];
   end
   for (genvar g = 0; g < OUT_CHANNELS; g++) begin : g_b
      assign b_arr[g] = bias_flat[g*DATA_WIDTH +: DATA_WIDTH];
   end
   for (genvar g = 0; g < OUT_SIZE; g++) begin : g_o
      assign output_tensor_flat[g*DATA_WIDTH +: DATA_WIDTH] = out_q[g];
   end

   state_e state_q, state_d;
   idx_t   b_q, oc_q, oy_q, ox_q, ic_q, ky_q, kx_q;
   idx_t   b_d, oc_d, oy_d, ox_d, ic_d, ky_d, kx_d;
   data_t  acc_q, acc_d, in_val_q, in_val_d, w_val_q, w_val_d;
   logic   tap_ok_q, tap_ok_d, done_q, done_d, valid_q, valid_d;

   logic  tap_ok;
   idx_t  in_off, w_off, slot;
   data_t store_val;
   logic  last_tap, last_out;

   convt_tap_gen #(
      .IN_CHANNELS (IN_CHANNELS),
      .OUT_CHANNELS(OUT_CHANNELS),
      .IN_HEIGHT   (IN_HEIGHT),
      .IN_WIDTH    (IN_WIDTH),
      .KERNEL_SIZE (KERNEL_SIZE),
      .STRIDE      (STRIDE),
      .PADDING     (PADDING)
   ) u_tap (
      .b_i     (b_q),
      .ic_i    (ic_q),
      .oc_i    (oc_q),
      .oy_i    (oy_q),
      .ox_i    (ox_q),
      .ky_i    (ky_q),
      .kx_i    (kx_q),
      .tap_ok_o(tap_ok),
      .in_off_o(in_off),
      .w_off_o (w_off)
   );

   assign last_tap = (ic_q == idx_t'(IN_CHANNELS-1))
                  && (ky_q == idx_t'(KERNEL_SIZE-1))
                  && (kx_q == idx_t'(KERNEL_SIZE-1));
   assign last_out = (b_q  == idx_t'(BATCH_SIZE-1))
                  && (oc_q == idx_t'(OUT_CHANNELS-1))
                  && (oy_q == idx_t'(OUT_HEIGHT-1))
                  && (ox_q == idx_t'(OUT_WIDTH-1));
   assign slot = idx4(b_q, oc_q, oy_q, ox_q,
                      OUT_CHANNELS, OUT_HEIGHT, OUT_WIDTH);

`ifdef CONVT_RELU_EN
   assign store_val = acc_q[DATA_WIDTH-1] ? '0 : acc_q;
`else
   assign store_val = acc_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (start) state_d = INIT_OUT;
         INIT_OUT: state_d = SCAN_TAP;
         SCAN_TAP: state_d = MAC;
         MAC:      state_d = last_tap ? STORE : SCAN_TAP;
         STORE:    state_d = last_out ? DONE : INIT_OUT;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      b_d = b_q;  oc_d = oc_q; oy_d = oy_q; ox_d = ox_q;
      ic_d = ic_q; ky_d = ky_q; kx_d = kx_q;
      acc_d = acc_q; in_val_d = in_val_q; w_val_d = w_val_q;
      tap_ok_d = tap_ok_q; out_d = out_q;
      done_d = 1'b0; valid_d = valid_q;
      unique case (state_q)
         IDLE: if (start) begin
            b_d = '0; oc_d = '0; oy_d = '0; ox_d = '0;
            valid_d = 1'b0;
         end
         INIT_OUT: begin
            acc_d = b_arr[oc_q[BA-1:0]];
            ic_d = '0; ky_d = '0; kx_d = '0;
         end
         SCAN_TAP: begin
            in_val_d = in_arr[in_off[IA-1:0]];
            w_val_d  = w_arr[w_off[WA-1:0]];
            tap_ok_d = tap_ok;
         end
         MAC: begin
            acc_d = acc_q + (tap_ok_q ? data_t'(in_val_q * w_val_q) : '0);
            if (kx_q != idx_t'(KERNEL_SIZE-1)) kx_d = kx_q + 1;
            else begin
               kx_d = '0;
               if (ky_q != idx_t'(KERNEL_SIZE-1)) ky_d = ky_q + 1;
               else begin
                  ky_d = '0;
                  ic_d = ic_q + 1;
               end
            end
         end
         STORE: begin
            out_d[slot[OA-1:0]] = store_val;
            if (ox_q != idx_t'(OUT_WIDTH-1)) ox_d = ox_q + 1;
            else begin
               ox_d = '0;
               if (oy_q != idx_t'(OUT_HEIGHT-1)) oy_d = oy_q + 1;
               else begin
                  oy_d = '0;
                  if (oc_q != idx_t'(OUT_CHANNELS-1)) oc_d = oc_q + 1;
                  else begin
                     oc_d = '0;
                     b_d  = b_q + 1;
                  end
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b_q <= '0; oc_q <= '0; oy_q <= '0; ox_q <= '0;
         ic_q <= '0; ky_q <= '0; kx_q <= '0;
         acc_q <= '0; in_val_q <= '0; w_val_q <= '0; tap_ok_q <= 1'b0;
         done_q <= 1'b0; valid_q <= 1'b0;
         for (int i = 0; i < OUT_SIZE; i++) out_q[i] <= '0;
      end else begin
         b_q <= b_d; oc_q <= oc_d; oy_q <= oy_d; ox_q <= ox_d;
         ic_q <= ic_d; ky_q <= ky_d; kx_q <= kx_d;
         acc_q <= acc_d; in_val_q <= in_val_d; w_val_q <= w_val_d;
         tap_ok_q <= tap_ok_d;
         done_q <= done_d; valid_q <= valid_d;
         out_q <= out_d;
      end
   end

   assign done  = done_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_conv_transpose2d.sv
// Scoreboard bench for conv_transpose2d: default stride-2 instance and a
// stride-1 overlapping instance, checked against a scatter-form model.
module tb_conv_transpose2d;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0, start1 = 1'b0;
   logic [127:0]  in0 = '0, in1 = '0;
   logic [255:0]  w0 = '0;
   logic [127:0]  w1 = '0;
   logic [63:0]   b0 = '0;
   logic [31:0]   b1 = '0;
   logic [1023:0] out0;
   logic [287:0]  out1;
   logic done0, valid0, done1, valid1;

   int checks = 0;
   int failures = 0;
   int in_a [16];
   int w_a [16];
   int bias_a [4];
   logic [31:0] expq [$];
   int ndone0 = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (done0) ndone0++;

   conv_transpose2d u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .input_tensor_flat(in0), .weights_flat(w0), .bias_flat(b0),
      .output_tensor_flat(out0), .done(done0), .valid(valid0)
   );

   conv_transpose2d #(
      .OUT_CHANNELS(1), .STRIDE(1)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .input_tensor_flat(in1), .weights_flat(w1), .bias_flat(b1),
      .output_tensor_flat(out1), .done(done1), .valid(valid1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load(input int which);
      if (which == 0) begin
         for (int i = 0; i < 4; i++) in0[i*32 +: 32] = in_a[i];
         for (int i = 0; i < 8; i++) w0[i*32 +: 32] = w_a[i];
         for (int i = 0; i < 2; i++) b0[i*32 +: 32] = bias_a[i];
      end else begin
         for (int i = 0; i < 4; i++) in1[i*32 +: 32] = in_a[i];
         for (int i = 0; i < 4; i++) w1[i*32 +: 32] = w_a[i];
         b1 = bias_a[0];
      end
   endtask

   // Scatter each input pixel through the kernel into the output map.
   task automatic push_model(input int which);
      int ocn, s, oh, ow, oy, ox, v;
      int acc [64];
      ocn = (which == 0) ? 2 : 1;
      s   = (which == 0) ? 2 : 1;
      oh  = (2 - 1)*s + 2;
      ow  = oh;
      for (int oc = 0; oc < ocn; oc++)
         for (int p = 0; p < oh*ow; p++) acc[oc*oh*ow + p] = bias_a[oc];
      for (int oc = 0; oc < ocn; oc++)
         for (int iy = 0; iy < 2; iy++)
            for (int ix = 0; ix < 2; ix++)
               for (int ky = 0; ky < 2; ky++)
                  for (int kx = 0; kx < 2; kx++) begin
                     oy = iy*s + ky;
                     ox = ix*s + kx;
                     if (oy < oh && ox < ow)
                        acc[(oc*oh + oy)*ow + ox] +=
                           in_a[iy*2 + ix] * w_a[(oc*2 + ky)*2 + kx];
                  end
      for (int i = 0; i < ocn*oh*ow; i++) begin
         v = acc[i];
`ifdef CONVT_RELU_EN
         if (v < 0) v = 0;
`endif
         expq.push_back(v);
      end
   endtask

   task automatic set_start(input int which, input logic v);
      if (which == 0) start0 = v;
      else            start1 = v;
   endtask

   task automatic run(input int which, input int exp_lat,
                      input int rst_at, input int pulse_at);
      int cyc, n;
      logic dn;
      n = (which == 0) ? 32 : 9;
      @(posedge clk); #1;
      set_start(which, 1'b1);
      @(posedge clk); #1;
      set_start(which, 1'b0);
      cyc = 0;
      dn = 1'b0;
      while (!dn && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1)
            chk("valid_clr", (which == 0) ? valid0 : valid1, 0);
         if (cyc == pulse_at)     set_start(which, 1'b1);
         if (cyc == pulse_at + 1) set_start(which, 1'b0);
         if (cyc == rst_at) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk("rst_done",  done0, 0);
            chk("rst_valid", valid0, 0);
            chk("rst_out",   {31'b0, |out0}, 0);
            rst_n = 1'b1;
            expq.delete();
            return;
         end
         dn = (which == 0) ? done0 : done1;
      end
      chk($sformatf("latency%0d", which), cyc, exp_lat);
      chk($sformatf("valid%0d", which), (which == 0) ? valid0 : valid1, 1);
      for (int i = 0; i < n; i++) begin
         logic [31:0] e, g;
         e = expq.pop_front();
         g = (which == 0) ? out0[i*32 +: 32] : out1[i*32 +: 32];
         chk($sformatf("out%0d_%0d", which, i), g, e);
      end
      @(posedge clk); #1;
      chk("done_pulse", (which == 0) ? done0 : done1, 0);
      chk("valid_hold", (which == 0) ? valid0 : valid1, 1);
   endtask

   task automatic set_job_a();
      for (int i = 0; i < 4; i++) in_a[i] = i;
      for (int i = 0; i < 8; i++) w_a[i] = 1;
      bias_a[0] = 0;
      bias_a[1] = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", valid0, 0);
      chk("reset_done",  done0, 0);
      chk("reset_out",   {31'b0, |out0}, 0);
      chk("reset_valid1", valid1, 0);
      rst_n = 1'b1;

      set_job_a();
      load(0);
      push_model(0);
      run(0, 321, 0, 0);

      bias_a[0] = 5;
      bias_a[1] = -3;
      load(0);
      push_model(0);
      run(0, 321, 0, 0);

      for (int i = 0; i < 4; i++) w_a[i] = -1;
      for (int i = 4; i < 8; i++) w_a[i] = 1;
      bias_a[0] = 0;
      bias_a[1] = 0;
      load(0);
      push_model(0);
      run(0, 321, 0, 0);

      set_job_a();
      load(0);
      push_model(0);
      run(0, 321, 50, 0);

      push_model(0);
      ndone0 = 0;
      run(0, 321, 0, 100);
      chk("one_done", ndone0, 1);

      for (int i = 0; i < 4; i++) in_a[i] = i + 1;
      for (int i = 0; i < 4; i++) w_a[i] = 1;
      bias_a[0] = 0;
      load(1);
      push_model(1);
      run(1, 91, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
